// File: rtl/cordic_gain_expander.sv
// Sequential multiply of a signed sample by the CORDIC gain K (~1.6467590). One
// shift-add term is applied per clock, and the result saturates to the output width.
module cordic_gain_expander #(
  parameter int unsigned DATA_WIDTH = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  sat_o
);

  localparam int unsigned AccWidth = DATA_WIDTH + 2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic signed [AccWidth-1:0] AccMax = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AccWidth-1:0] AccMin = {3'b111, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                   state_q, state_d;
  logic [2:0]                   cnt_q, cnt_d;
  logic signed [AccWidth-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        sample_q, sample_d;
  logic [DATA_WIDTH-1:0]        data_out_q, data_out_d;
  logic                         sat_q, sat_d;
  logic                         out_valid_q, out_valid_d;

  logic [3:0]                   shift_amt;
  logic signed [AccWidth-1:0]   sample_ext;
  logic signed [AccWidth-1:0]   term;
  logic [DATA_WIDTH-1:0]        sat_data;
  logic                         sat_flag;

  // Shift-add decomposition of K: 1 + 2^-1 + 2^-3 + 2^-6 + 2^-8 + 2^-9 + 2^-12 + 2^-15.
  always_comb begin
    shift_amt = 4'd0;
    unique case (cnt_q)
      3'd0: shift_amt = 4'd0;
      3'd1: shift_amt = 4'd1;
      3'd2: shift_amt = 4'd3;
      3'd3: shift_amt = 4'd6;
      3'd4: shift_amt = 4'd8;
      3'd5: shift_amt = 4'd9;
      3'd6: shift_amt = 4'd12;
      3'd7: shift_amt = 4'd15;
      default: shift_amt = 4'd0;
    endcase
  end

  assign sample_ext = $signed({{(AccWidth-DATA_WIDTH){sample_q[DATA_WIDTH-1]}}, sample_q});
  assign term       = sample_ext >>> shift_amt;

  always_comb begin
    sat_flag = 1'b0;
    sat_data = acc_q[DATA_WIDTH-1:0];
    if (acc_q > AccMax) begin
      sat_flag = 1'b1;
      sat_data = AccMax[DATA_WIDTH-1:0];
    end else if (acc_q < AccMin) begin
      sat_flag = 1'b1;
      sat_data = AccMin[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sample_d    = sample_q;
    data_out_d  = data_out_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          sample_d = data_in_i;
          acc_d    = '0;
          cnt_d    = 3'd0;
          state_d  = StAcc;
        end
      end
      StAcc: begin
        acc_d = acc_q + term;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StDone;
      end
      StDone: begin
        // First DONE cycle registers the final accumulator; later cycles wait for the sink.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          data_out_d  = sat_data;
          sat_d       = sat_flag;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      acc_q       <= '0;
      sample_q    <= '0;
      data_out_q  <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sample_q    <= sample_d;
      data_out_q  <= data_out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = out_valid_q;
  assign data_out_o  = data_out_q;
  assign sat_o       = sat_q;

endmodule
